// File: rtl/lsb_hex_ctrl.sv
// Eight-digit seven-segment controller on the stb/we/ack I/O bus (VALUE + CTRL registers).
// Latency: bus ack/read data combinational; segment outputs registered, one cycle after a register write.
// Backpressure: none; ack follows stb every cycle, so every access completes in one cycle.
module lsb_hex_ctrl #(
    parameter int BLINK_DIV = 20000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic [6:0]  hex7_n,
    output logic [6:0]  hex6_n,
    output logic [6:0]  hex5_n,
    output logic [6:0]  hex4_n,
    output logic [6:0]  hex3_n,
    output logic [6:0]  hex2_n,
    output logic [6:0]  hex1_n,
    output logic [6:0]  hex0_n
);

    localparam int              CW        = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(BLINK_DIV - 1);
    // Only en, blink_mask, blink_en and test are implemented; the rest read as 0.
    localparam logic [31:0]     CTRL_MASK = 32'h0101_FFFF;
    localparam logic [6:0]      SEG_BLANK = 7'h7F;
    localparam logic [6:0]      SEG_ALL   = 7'h00;

    logic [31:0]       value;
    logic [31:0]       ctrl;
    logic [CW-1:0]     cnt;
    logic              phase;
    logic              wr_value;
    logic              wr_ctrl;
    logic [7:0][6:0]   seg_next;
    logic [7:0][6:0]   seg_q;

    assign wr_value = stb & we & ~addr;
    assign wr_ctrl  = stb & we & addr;
    assign ack      = stb;

    // Nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Register file writes; undefined CTRL bits are dropped on the way in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            ctrl  <= '0;
        end else begin
            if (wr_value) value <= data_in;
            if (wr_ctrl)  ctrl  <= data_in & CTRL_MASK;
        end
    end

    // Blink prescaler; a CTRL write restarts it so blinking begins in the visible half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wr_ctrl) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Per-digit priority: test override, then enable, then blink, then decoded nibble.
    always_comb begin
        seg_next = '0;
        for (int i = 0; i < 8; i++) begin
            if (ctrl[24])
                seg_next[i] = SEG_ALL;
            else if (!ctrl[i])
                seg_next[i] = SEG_BLANK;
            else if (ctrl[16] && ctrl[8+i] && phase)
                seg_next[i] = SEG_BLANK;
            else
                seg_next[i] = decode(value[4*i +: 4]);
        end
    end

    // Registered segment outputs; reset blanks the display without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_q <= {8{SEG_BLANK}};
        else        seg_q <= seg_next;
    end

    // Combinational read mux; the bus is driven only during a read strobe.
    always_comb begin
        data_out = '0;
        if (stb && !we) data_out = addr ? ctrl : value;
    end

    assign hex0_n = seg_q[0];
    assign hex1_n = seg_q[1];
    assign hex2_n = seg_q[2];
    assign hex3_n = seg_q[3];
    assign hex4_n = seg_q[4];
    assign hex5_n = seg_q[5];
    assign hex6_n = seg_q[6];
    assign hex7_n = seg_q[7];

endmodule
